// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared op encodings, FSM states and helpers for the sequential divider
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    function automatic logic is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/response bundle between the EX stage and the divider
interface seq_divider_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         kill;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, op, a, b, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, kill,
        output busy, done, result
    );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem,
    input  logic         dvd_msb,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);
    logic [N:0] shifted;
    logic [N:0] trial;

    assign shifted = {rem, dvd_msb};
    // Bit N of the trial difference is the borrow: clear means the divisor fit.
    assign trial   = shifted + ~{1'b0, divisor} + {{N{1'b0}}, 1'b1};
    assign q_bit   = ~trial[N];
    // Partial remainder stays below the divisor, so N bits always hold it.
    assign rem_next = q_bit ? trial[N-1:0] : shifted[N-1:0];
endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider for DIV/DIVU/REM/REMU
module seq_divider
    import div_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  dif
);
    state_e             state;
    logic [1:0]         op_r;
    logic               sa, sb;
    logic [N-1:0]       dvd;
    logic [N-1:0]       divisor;
    logic [N-1:0]       rem;
    logic [CNT_W-1:0]   cnt;
    logic               busy_r, done_r;
    logic [N-1:0]       result_r;

    logic [N-1:0]       step_rem;
    logic               step_q;

    logic               in_signed, a_neg, b_neg, b_zero, ovf;
    logic [N-1:0]       special_res, q_fix, r_fix;

    function automatic logic [N-1:0] neg(input logic [N-1:0] v);
        return ~v + {{(N-1){1'b0}}, 1'b1};
    endfunction

    div_step #(.N(N)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[N-1]),
        .divisor  (divisor),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    assign in_signed = is_signed(dif.op);
    assign a_neg     = in_signed & dif.a[N-1];
    assign b_neg     = in_signed & dif.b[N-1];
    assign b_zero    = (dif.b == '0);
    assign ovf       = in_signed & (dif.a == {1'b1, {(N-1){1'b0}}}) & (dif.b == '1);

    always_comb begin
        special_res = '0;
        if (b_zero)
            special_res = is_rem(dif.op) ? dif.a : '1;
        else if (ovf)
            special_res = is_rem(dif.op) ? '0 : dif.a;
    end

    // Quotient register doubles as the shifting dividend; signs were captured on accept.
    assign q_fix = (sa ^ sb) ? neg(dvd) : dvd;
    assign r_fix = sa ? neg(rem) : rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_r     <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            dvd      <= '0;
            divisor  <= '0;
            rem      <= '0;
            cnt      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else if (dif.kill) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (dif.start) begin
                        op_r    <= dif.op;
                        sa      <= a_neg;
                        sb      <= b_neg;
                        dvd     <= a_neg ? neg(dif.a) : dif.a;
                        divisor <= b_neg ? neg(dif.b) : dif.b;
                        rem     <= '0;
                        cnt     <= CNT_W'(N - 1);
                        busy_r  <= 1'b1;
                        if (b_zero || ovf) begin
                            result_r <= special_res;
                            done_r   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= step_rem;
                    dvd <= {dvd[N-2:0], step_q};
                    if (cnt == '0)
                        state <= FIX;
                    else
                        cnt <= cnt - 1'b1;
                end
                FIX: begin
                    result_r <= is_rem(op_r) ? r_fix : q_fix;
                    done_r   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dif.busy   = busy_r;
    assign dif.done   = done_r;
    assign dif.result = result_r;
endmodule
